alu_muldiv: RTL and testbench
=============================

// Module: alu_muldiv
// PURPOSE
//  Iterative multiply/divide unit for the execute stage; it sits beside the combinational ALU.
//  Runs MIPS MULT/MULTU/DIV/DIVU over DATA_BITS cycles and holds the results in the HI/LO registers.
//  Accepts MTHI/MTLO writes and drives busy_e so the hazard unit stalls MFHI/MFLO and a new mul/div.
//  Parametrised in width so the same block serves 32-bit and narrower test datapaths.
// PARAMETERS
//  DATA_BITS  32  operand/result width (>=4); HI and LO are each DATA_BITS wide
//  CNT_BITS   $clog2(DATA_BITS)  iteration counter width (derived, do not override)
// PORTS
//  clk        in   1          single clock; all state updates on rising edge
//  rst_n      in   1          synchronous, active-low reset
//  start_e    in   1          request a new operation; sampled only in IDLE
//  op_e       in   2          00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  src_a_e    in   DATA_BITS  multiplicand / dividend
//  src_b_e    in   DATA_BITS  multiplier / divisor
//  flush_e    in   1          abort the in-flight operation (branch/exception squash)
//  mthi_e     in   1          write wdata_e into HI
//  mtlo_e     in   1          write wdata_e into LO
//  wdata_e    in   DATA_BITS  MTHI/MTLO data
//  busy_e     out  1          operation in flight (state != IDLE)
//  done_e     out  1          one-cycle pulse in the FINISH state
//  hi_out_e   out  DATA_BITS  HI register (product upper half / remainder)
//  lo_out_e   out  DATA_BITS  LO register (product lower half / quotient)
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, cnt=0, HI=LO=0, busy_e=0, done_e=0; reset wins over all inputs.
//  FSM: IDLE -start_e-> CALC -(cnt==0)-> FINISH -> IDLE. flush_e in CALC or FINISH -> IDLE next edge.
//  Accept (IDLE & start_e): latch op. Signed ops (MULT/DIV): latch |a| and |b|, then record
//   neg_q = a[msb]^b[msb] and neg_r = a[msb]. Set cnt = DATA_BITS-1.
//  CALC: one bit per cycle, DATA_BITS cycles total; cnt decrements each cycle.
//   MUL: shift-add into a 2*DATA_BITS accumulator.
//   DIV: restoring; subtract divisor from partial remainder, keep result if non-negative, shift in quotient bit.
//  FINISH: done_e=1 for exactly this cycle; apply sign fix (negate product if neg_q; quotient if neg_q;
//   remainder if neg_r); write HI/LO at this edge; the new values are visible the cycle after done_e.
//  Latency: start sampled at edge k -> done_e high in cycle k+DATA_BITS+1 -> busy_e low from k+DATA_BITS+2.
//  busy_e is 1 from the edge after acceptance through the FINISH cycle inclusive.
//  start_e while busy_e=1: ignored, with no queueing; the pipeline must stall.
//  Divide by zero: no trap. LO = all ones, HI = dividend (raw src_a_e), same latency.
//  Signed overflow (DIV most-negative / -1): LO = most-negative, HI = 0 (falls out of abs/negate math).
//  MTHI/MTLO: take effect at the edge, only in IDLE. In other states they are dropped.
//   In IDLE with start_e=1: start is accepted and the MT write is dropped.
//   mthi_e and mtlo_e together: both written.
//  Flush: the aborted operation never writes HI/LO and no done_e is issued. HI/LO keep their old values.
//   flush_e in IDLE has no effect.
//   flush_e and start_e in the same IDLE cycle: the start is accepted (squash of an older instruction only).
//  Products: MULT is full signed 2*DATA_BITS, MULTU unsigned; HI={prod[2W-1:W]}, LO=prod[W-1:0].
// TESTING
//  MULTU 0xFFFFFFFF*0xFFFFFFFF -> done_e at cycle start+33; HI=0xFFFFFFFE, LO=0x00000001.
//  MULT -7*3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  DIVU 100/0 -> LO=0xFFFFFFFF, HI=100. DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
//  Start MULT 5*5 with HI/LO=0x11/0x22; flush_e at cycle start+10 -> busy_e=0 next cycle, no done_e,
//   HI/LO stay 0x11/0x22; a new DIVU 9/4 started next cycle -> LO=2, HI=1.
//  mtlo_e wdata 0xABCD while busy -> LO unchanged after FINISH result; mtlo_e in IDLE -> LO=0xABCD next cycle.
//  rst_n=0 at cycle start+5 mid-CALC -> next cycle busy_e=0, HI=LO=0; start_e held during reset is ignored.
//  DATA_BITS=8: MULTU 0xFF*0x02 -> done_e at start+9; HI=0x01, LO=0xFE.

Source files
------------

// File: rtl/alu_muldiv.sv
// Iterative MIPS multiply/divide unit with HI/LO registers for the execute stage.
// One product/quotient bit per cycle; busy_e stalls MFHI/MFLO and back-to-back mul/div.
module alu_muldiv #(
    parameter int DATA_BITS = 32,
    parameter int CNT_BITS  = $clog2(DATA_BITS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_e,
    input  logic [1:0]           op_e,
    input  logic [DATA_BITS-1:0] src_a_e,
    input  logic [DATA_BITS-1:0] src_b_e,
    input  logic                 flush_e,
    input  logic                 mthi_e,
    input  logic                 mtlo_e,
    input  logic [DATA_BITS-1:0] wdata_e,
    output logic                 busy_e,
    output logic                 done_e,
    output logic [DATA_BITS-1:0] hi_out_e,
    output logic [DATA_BITS-1:0] lo_out_e
);

    localparam int W = DATA_BITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_BITS-1:0]  cnt;
    logic                 accept;
    logic                 commit;

    // acc holds {partial product} for MUL and {partial remainder, quotient} for DIV
    logic [2*W-1:0]       acc;
    logic [W-1:0]         opnd;
    logic                 is_div;
    logic                 neg_q;
    logic                 neg_r;
    logic                 div_zero;

    logic                 signed_op;
    logic [W-1:0]         abs_a;
    logic [W-1:0]         abs_b;

    logic [W:0]           mul_sum;
    logic [W:0]           div_shift;
    logic [W:0]           div_diff;

    logic [2*W-1:0]       prod_fix;
    logic [W-1:0]         q_fix;
    logic [W-1:0]         r_fix;
    logic [W-1:0]         res_hi;
    logic [W-1:0]         res_lo;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nxt = state;
        busy_e    = 1'b0;
        done_e    = 1'b0;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (start_e) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                busy_e = 1'b1;
                if (flush_e) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                busy_e    = 1'b1;
                done_e    = !flush_e;
                commit    = !flush_e;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand conditioning and per-cycle step
    // ------------------------------------------------------------------
    always_comb begin
        signed_op = !op_e[0];
        abs_a     = (signed_op && src_a_e[W-1]) ? -src_a_e : src_a_e;
        abs_b     = (signed_op && src_b_e[W-1]) ? -src_b_e : src_b_e;
    end

    always_comb begin
        mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = {acc[2*W-1:W], acc[W-1]};
        div_diff  = div_shift - {1'b0, opnd};
    end

    // NOTE: the datapath registers carry no reset; they are always loaded on
    // accept before being read, so resetting them would only cost routing.
    always_ff @(posedge clk) begin
        if (accept) begin
            is_div   <= op_e[1];
            neg_q    <= signed_op && (src_a_e[W-1] ^ src_b_e[W-1]);
            neg_r    <= signed_op && src_a_e[W-1];
            div_zero <= op_e[1] && (src_b_e == '0);
            opnd     <= op_e[1] ? abs_b : abs_a;
            acc      <= {{W{1'b0}}, (op_e[1] ? abs_a : abs_b)};
        end else if (state == CALC) begin
            if (is_div) begin
                // Restoring step: keep the difference only when it did not borrow
                if (div_diff[W]) begin
                    acc <= {div_shift[W-1:0], acc[W-2:0], 1'b0};
                end else begin
                    acc <= {div_diff[W-1:0], acc[W-2:0], 1'b1};
                end
            end else begin
                acc <= {mul_sum, acc[W-1:1]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Sign fix and result select
    // ------------------------------------------------------------------
    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        // Divide by zero: the restoring loop leaves |a| as remainder, and the
        // neg_r fix turns it back into the raw dividend.
        q_fix    = div_zero ? {W{1'b1}} : (neg_q ? -acc[W-1:0] : acc[W-1:0]);
        r_fix    = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];
        res_hi   = is_div ? r_fix : prod_fix[2*W-1:W];
        res_lo   = is_div ? q_fix : prod_fix[W-1:0];
    end

    // ------------------------------------------------------------------
    // Iteration counter and HI/LO architectural registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            hi_out_e <= '0;
            lo_out_e <= '0;
        end else begin
            if (accept) begin
                cnt <= CNT_BITS'(W - 1);
            end else if (state == CALC) begin
                cnt <= cnt - 1'b1;
            end

            if (commit) begin
                hi_out_e <= res_hi;
                lo_out_e <= res_lo;
            end else if (state == IDLE && !start_e) begin
                if (mthi_e) begin
                    hi_out_e <= wdata_e;
                end
                if (mtlo_e) begin
                    lo_out_e <= wdata_e;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv: 32-bit instance plus an 8-bit instance,
// hand-computed expected HI/LO, latency, flush, MT and reset behaviour.
module tb_alu_muldiv;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start_e;
    logic [1:0]  op_e;
    logic [31:0] src_a_e;
    logic [31:0] src_b_e;
    logic        flush_e;
    logic        mthi_e;
    logic        mtlo_e;
    logic [31:0] wdata_e;
    logic        busy_e;
    logic        done_e;
    logic [31:0] hi_out_e;
    logic [31:0] lo_out_e;

    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [7:0]  hi8;
    logic [7:0]  lo8;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_muldiv #(.DATA_BITS(32)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_e  (start_e),
        .op_e     (op_e),
        .src_a_e  (src_a_e),
        .src_b_e  (src_b_e),
        .flush_e  (flush_e),
        .mthi_e   (mthi_e),
        .mtlo_e   (mtlo_e),
        .wdata_e  (wdata_e),
        .busy_e   (busy_e),
        .done_e   (done_e),
        .hi_out_e (hi_out_e),
        .lo_out_e (lo_out_e)
    );

    alu_muldiv #(.DATA_BITS(8)) u_dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_e  (start8),
        .op_e     (op8),
        .src_a_e  (a8),
        .src_b_e  (b8),
        .flush_e  (1'b0),
        .mthi_e   (1'b0),
        .mtlo_e   (1'b0),
        .wdata_e  (8'h00),
        .busy_e   (busy8),
        .done_e   (done8),
        .hi_out_e (hi8),
        .lo_out_e (lo8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start one 32-bit op (optionally with a same-cycle flush), then check latency and result
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic fl, input string tag,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        op_e    = op;
        src_a_e = a;
        src_b_e = b;
        start_e = 1'b1;
        flush_e = fl;
        tick();
        start_e = 1'b0;
        flush_e = 1'b0;
        check({tag, " busy"}, 64'(busy_e), 64'd1);
        n = 0;
        while (done_e !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'd32);
        tick();
        check({tag, " busy_end"}, 64'(busy_e), 64'd0);
        check({tag, " done_pulse"}, 64'(done_e), 64'd0);
        check({tag, " hi"}, 64'(hi_out_e), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo_out_e), 64'(exp_lo));
    endtask

    task automatic do_op8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input string tag, input logic [7:0] exp_hi, input logic [7:0] exp_lo);
        int n;
        op8    = op;
        a8     = a;
        b8     = b;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n = 0;
        while (done8 !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'd8);
        tick();
        check({tag, " busy_end"}, 64'(busy8), 64'd0);
        check({tag, " hi"}, 64'(hi8), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo8), 64'(exp_lo));
    endtask

    initial begin
        int n;
        rst_n   = 1'b0;
        start_e = 1'b1;
        op_e    = OP_MULTU;
        src_a_e = 32'd3;
        src_b_e = 32'd4;
        flush_e = 1'b0;
        mthi_e  = 1'b1;
        mtlo_e  = 1'b1;
        wdata_e = 32'h5555_5555;
        start8  = 1'b1;
        op8     = OP_MULTU;
        a8      = 8'd3;
        b8      = 8'd4;

        // Reset wins over start and MT writes
        repeat (3) tick();
        check("reset busy", 64'(busy_e), 64'd0);
        check("reset done", 64'(done_e), 64'd0);
        check("reset hi", 64'(hi_out_e), 64'd0);
        check("reset lo", 64'(lo_out_e), 64'd0);
        check("reset busy8", 64'(busy8), 64'd0);
        check("reset hi8", 64'(hi8), 64'd0);
        start_e = 1'b0;
        mthi_e  = 1'b0;
        mtlo_e  = 1'b0;
        start8  = 1'b0;
        rst_n   = 1'b1;
        tick();
        check("post-reset idle", 64'(busy_e), 64'd0);

        // Arithmetic
        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu max", 32'hFFFF_FFFE, 32'h0000_0001);
        do_op(OP_MULT,  32'hFFFF_FFF9, 32'd3,         1'b0, "mult -7*3", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        do_op(OP_MULT,  32'hFFFF_FFFB, 32'hFFFF_FFFA, 1'b0, "mult -5*-6", 32'h0000_0000, 32'h0000_001E);
        do_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0, "mult minneg^2", 32'h4000_0000, 32'h0000_0000);
        do_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         1'b0, "div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, 1'b0, "div 7/-2", 32'h0000_0001, 32'hFFFF_FFFD);
        do_op(OP_DIVU,  32'hFFFF_FFFF, 32'h10,        1'b0, "divu max/16", 32'h0000_000F, 32'h0FFF_FFFF);
        do_op(OP_DIVU,  32'd100,       32'd0,         1'b0, "divu 100/0", 32'd100, 32'hFFFF_FFFF);
        do_op(OP_DIV,   32'hFFFF_FFF9, 32'd0,         1'b0, "div -7/0", 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div ovf", 32'h0000_0000, 32'h8000_0000);

        // MTHI and MTLO together, then individually
        mthi_e  = 1'b1;
        mtlo_e  = 1'b1;
        wdata_e = 32'h77;
        tick();
        mthi_e  = 1'b0;
        mtlo_e  = 1'b0;
        check("mt both hi", 64'(hi_out_e), 64'h77);
        check("mt both lo", 64'(lo_out_e), 64'h77);
        mthi_e  = 1'b1;
        wdata_e = 32'h11;
        tick();
        mthi_e  = 1'b0;
        mtlo_e  = 1'b1;
        wdata_e = 32'h22;
        tick();
        mtlo_e  = 1'b0;
        check("mthi", 64'(hi_out_e), 64'h11);
        check("mtlo", 64'(lo_out_e), 64'h22);

        // Flush mid-CALC: no done, HI/LO untouched
        op_e    = OP_MULT;
        src_a_e = 32'd5;
        src_b_e = 32'd5;
        start_e = 1'b1;
        tick();
        start_e = 1'b0;
        repeat (9) tick();
        flush_e = 1'b1;
        tick();
        flush_e = 1'b0;
        check("flush busy", 64'(busy_e), 64'd0);
        check("flush done", 64'(done_e), 64'd0);
        check("flush hi", 64'(hi_out_e), 64'h11);
        check("flush lo", 64'(lo_out_e), 64'h22);
        // Start together with a flush in IDLE is still accepted
        do_op(OP_DIVU, 32'd9, 32'd4, 1'b1, "divu 9/4", 32'd1, 32'd2);

        // MT writes dropped while busy and when coincident with start
        op_e    = OP_MULTU;
        src_a_e = 32'd3;
        src_b_e = 32'd4;
        start_e = 1'b1;
        mthi_e  = 1'b1;
        wdata_e = 32'h99;
        tick();
        start_e = 1'b0;
        mthi_e  = 1'b0;
        repeat (3) tick();
        mtlo_e  = 1'b1;
        wdata_e = 32'hABCD;
        tick();
        mtlo_e  = 1'b0;
        n = 0;
        while (done_e !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("mt busy latency", 64'(n), 64'd28);
        tick();
        check("mt busy hi", 64'(hi_out_e), 64'd0);
        check("mt busy lo", 64'(lo_out_e), 64'd12);
        mtlo_e  = 1'b1;
        wdata_e = 32'hABCD;
        tick();
        mtlo_e  = 1'b0;
        check("mtlo idle", 64'(lo_out_e), 64'hABCD);

        // Reset mid-CALC with start held
        op_e    = OP_MULT;
        src_a_e = 32'd5;
        src_b_e = 32'd5;
        start_e = 1'b1;
        tick();
        start_e = 1'b0;
        repeat (4) tick();
        rst_n   = 1'b0;
        start_e = 1'b1;
        tick();
        check("midreset busy", 64'(busy_e), 64'd0);
        check("midreset hi", 64'(hi_out_e), 64'd0);
        check("midreset lo", 64'(lo_out_e), 64'd0);
        tick();
        check("midreset hold", 64'(busy_e), 64'd0);
        rst_n   = 1'b1;
        start_e = 1'b0;
        tick();
        check("midreset release", 64'(busy_e), 64'd0);

        // Narrow datapath
        do_op8(OP_MULTU, 8'hFF, 8'h02, "w8 multu", 8'h01, 8'hFE);
        do_op8(OP_MULT,  8'hF9, 8'h03, "w8 mult -7*3", 8'hFF, 8'hEB);
        do_op8(OP_DIV,   8'h81, 8'h03, "w8 div -127/3", 8'hFF, 8'hD6);
        do_op8(OP_DIV,   8'h80, 8'hFF, "w8 div ovf", 8'h00, 8'h80);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
